dec10b8b_lanes: RTL and testbench

//  Multi-lane, pipelined decoder for the team's 5+5 split-weight 10-bit line code. Each lane

---
 rtl/dec10b8b_lanes.sv | 185 ++++++++++++++++++
 tb/tb_dec10b8b_lanes.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dec10b8b_lanes.sv
// Multi-lane two-stage decoder for the 5+5 split-weight 10-bit line code, with
// valid/ready on both sides and per-lane saturating violation counters.
module dec10b8b_lanes #(
  parameter int unsigned LANES    = 4,
  parameter int unsigned CNT_W    = 8,
  parameter int unsigned DROP_ERR = 0
) (
  input  logic                   clk_i,
  input  logic                   reset_n_i,
  input  logic                   clear_i,
  input  logic                   v_i,
  output logic                   ready_o,
  input  logic [10*LANES-1:0]    data_i,
  output logic                   v_o,
  input  logic                   ready_i,
  output logic [8*LANES-1:0]     data_o,
  output logic [LANES-1:0]       k_o,
  output logic [LANES-1:0]       err_o,
  output logic [CNT_W*LANES-1:0] err_cnt_o,
  output logic                   err_sticky_o
);

  typedef enum logic [2:0] {W_BAD, W_1, W_2, W_3, W_4} wclass_t;

  typedef struct packed {
    wclass_t    w;
    logic [3:0] idx;
  } half_t;

  typedef struct packed {
    logic [7:0] dat;
    logic       k;
    logic       e;
  } dec_t;

  function automatic half_t classify(input logic [4:0] h);
    half_t r;
    r = '{w: W_BAD, idx: 4'd0};
    case (h)
      5'b00111: r = '{w: W_3, idx: 4'd0};
      5'b01011: r = '{w: W_3, idx: 4'd1};
      5'b01101: r = '{w: W_3, idx: 4'd2};
      5'b01110: r = '{w: W_3, idx: 4'd3};
      5'b10011: r = '{w: W_3, idx: 4'd4};
      5'b10101: r = '{w: W_3, idx: 4'd5};
      5'b10110: r = '{w: W_3, idx: 4'd6};
      5'b11001: r = '{w: W_3, idx: 4'd7};
      5'b11010: r = '{w: W_3, idx: 4'd8};
      5'b11100: r = '{w: W_3, idx: 4'd9};
      5'b00011: r = '{w: W_2, idx: 4'd0};
      5'b00101: r = '{w: W_2, idx: 4'd1};
      5'b00110: r = '{w: W_2, idx: 4'd2};
      5'b01010: r = '{w: W_2, idx: 4'd3};
      5'b01100: r = '{w: W_2, idx: 4'd4};
      5'b01001: r = '{w: W_2, idx: 4'd5};
      5'b10001: r = '{w: W_2, idx: 4'd6};
      5'b10010: r = '{w: W_2, idx: 4'd7};
      5'b10100: r = '{w: W_2, idx: 4'd8};
      5'b11000: r = '{w: W_2, idx: 4'd9};
      5'b11110: r = '{w: W_4, idx: 4'd0};
      5'b11101: r = '{w: W_4, idx: 4'd1};
      5'b11011: r = '{w: W_4, idx: 4'd2};
      5'b10111: r = '{w: W_4, idx: 4'd3};
      5'b01111: r = '{w: W_4, idx: 4'd4};
      5'b00001: r = '{w: W_1, idx: 4'd0};
      5'b00010: r = '{w: W_1, idx: 4'd1};
      5'b00100: r = '{w: W_1, idx: 4'd2};
      5'b01000: r = '{w: W_1, idx: 4'd3};
      5'b10000: r = '{w: W_1, idx: 4'd4};
      default:  r = '{w: W_BAD, idx: 4'd0};
    endcase
    return r;
  endfunction

  // idx[3] marks index 8/9 of a 10-entry half; idx[2] marks index 4 of a 5-entry half
  function automatic dec_t decode(input half_t a, input half_t b);
    dec_t r;
    r = '0;
    if (a.w == W_3 && b.w == W_2) begin
      if (!a.idx[3] && !b.idx[3])     r.dat = {2'b00, a.idx[2:0], b.idx[2:0]};
      else if (a.idx[3] && !b.idx[3]) r.dat = {4'b1000, a.idx[0], b.idx[2:0]};
      else if (!a.idx[3])             r.dat = {4'b1010, b.idx[0], a.idx[2:0]};
      else                            r.dat = {6'b111100, a.idx[0], b.idx[0]};
    end else if (a.w == W_2 && b.w == W_3) begin
      if (!a.idx[3] && !b.idx[3])     r.dat = {2'b01, a.idx[2:0], b.idx[2:0]};
      else if (a.idx[3] && !b.idx[3]) r.dat = {4'b1001, a.idx[0], b.idx[2:0]};
      else if (!a.idx[3])             r.dat = {4'b1011, b.idx[0], a.idx[2:0]};
      else if (a.idx[0])              r.dat = {6'b111101, 1'b0, b.idx[0]};
      else begin
        r.k   = 1'b1;
        r.dat = {7'b0, b.idx[0]};
      end
    end else if (a.w == W_4 && b.w == W_1) begin
      if (!a.idx[2] && !b.idx[2])     r.dat = {4'b1100, a.idx[1:0], b.idx[1:0]};
      else if (a.idx[2] && !b.idx[2]) r.dat = {6'b111000, b.idx[1:0]};
      else if (!a.idx[2])             r.dat = {6'b111010, a.idx[1:0]};
      else                            r.dat = 8'hF6;
    end else if (a.w == W_1 && b.w == W_4) begin
      if (!a.idx[2] && !b.idx[2])     r.dat = {4'b1101, a.idx[1:0], b.idx[1:0]};
      else if (a.idx[2] && !b.idx[2]) r.dat = {6'b111001, b.idx[1:0]};
      else if (!a.idx[2])             r.dat = {6'b111011, a.idx[1:0]};
      else                            r.dat = 8'hF7;
    end else begin
      r.e = 1'b1;
    end
    return r;
  endfunction

  logic                        v1, v2, en1, en2;
  logic                        any_err, move, keep;
  half_t [LANES-1:0]           s1_a, s1_b;
  dec_t  [LANES-1:0]           dec;
  logic  [LANES-1:0]           lane_err;
  logic  [LANES-1:0][CNT_W-1:0] cnt;

  assign en2     = ~v2 | ready_i;
  assign en1     = ~v1 | en2;
  assign ready_o = en1;
  assign v_o     = v2;
  assign move    = v1 & en2;
  assign keep    = ~((DROP_ERR != 0) & any_err);
  assign err_cnt_o = cnt;

  always_comb begin
    dec      = '0;
    lane_err = '0;
    for (int unsigned n = 0; n < LANES; n++) begin
      dec[n]      = decode(s1_a[n], s1_b[n]);
      lane_err[n] = dec[n].e;
    end
  end

  assign any_err = |lane_err;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      v1   <= 1'b0;
      s1_a <= '0;
      s1_b <= '0;
    end else if (en1) begin
      v1 <= v_i;
      if (v_i) begin
        for (int unsigned n = 0; n < LANES; n++) begin
          s1_a[n] <= classify(data_i[10*n+5 +: 5]);
          s1_b[n] <= classify(data_i[10*n   +: 5]);
        end
      end
    end
  end

  // A dropped beat leaves S2 empty rather than holding stale output valid
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      v2     <= 1'b0;
      data_o <= '0;
      k_o    <= '0;
      err_o  <= '0;
    end else if (en2) begin
      v2 <= v1 & keep;
      if (v1 & keep) begin
        for (int unsigned n = 0; n < LANES; n++) begin
          data_o[8*n +: 8] <= dec[n].dat;
          k_o[n]           <= dec[n].k;
          err_o[n]         <= dec[n].e;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      cnt          <= '0;
      err_sticky_o <= 1'b0;
    end else if (clear_i) begin
      cnt          <= '0;
      err_sticky_o <= 1'b0;
    end else if (move) begin
      for (int unsigned n = 0; n < LANES; n++) begin
        if (lane_err[n] && cnt[n] != '1) cnt[n] <= cnt[n] + 1'b1;
      end
      if (any_err) err_sticky_o <= 1'b1;
    end
  end

endmodule

// File: tb/tb_dec10b8b_lanes.sv
// Table-driven, scoreboarded bench for dec10b8b_lanes across three parameter sets.
module tb_dec10b8b_lanes;
  localparam int unsigned NV = 28;

  typedef struct {
    logic [9:0] sym;
    logic [7:0] b;
    logic       k;
    logic       e;
  } vec_t;
  typedef struct packed { logic [31:0] d; logic [3:0] k; logic [3:0] e; } beat_a_t;
  typedef struct packed { logic [15:0] d; logic [1:0] k; logic [1:0] e; } beat_b_t;

  vec_t tbl [NV];
  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;

  // instance A: LANES=4, CNT_W=8, DROP_ERR=0
  logic a_v_i, a_ready_i, a_clear_i, a_ready_o, a_v_o, a_sticky;
  logic [39:0] a_data_i;
  logic [31:0] a_data_o, a_cnt;
  logic [3:0]  a_k_o, a_err_o;
  // instance B: LANES=2, CNT_W=2, DROP_ERR=1
  logic b_v_i, b_ready_i, b_clear_i, b_ready_o, b_v_o, b_sticky;
  logic [19:0] b_data_i;
  logic [15:0] b_data_o;
  logic [3:0]  b_cnt;
  logic [1:0]  b_k_o, b_err_o;
  // instance C: LANES=1, defaults
  logic c_v_i, c_ready_i, c_clear_i, c_ready_o, c_v_o, c_sticky;
  logic [9:0] c_data_i;
  logic [7:0] c_data_o, c_cnt;
  logic       c_k_o, c_err_o;

  dec10b8b_lanes #(.LANES(4), .CNT_W(8), .DROP_ERR(0)) u_a (
    .clk_i(clk), .reset_n_i(rst_n), .clear_i(a_clear_i), .v_i(a_v_i), .ready_o(a_ready_o),
    .data_i(a_data_i), .v_o(a_v_o), .ready_i(a_ready_i), .data_o(a_data_o), .k_o(a_k_o),
    .err_o(a_err_o), .err_cnt_o(a_cnt), .err_sticky_o(a_sticky));
  dec10b8b_lanes #(.LANES(2), .CNT_W(2), .DROP_ERR(1)) u_b (
    .clk_i(clk), .reset_n_i(rst_n), .clear_i(b_clear_i), .v_i(b_v_i), .ready_o(b_ready_o),
    .data_i(b_data_i), .v_o(b_v_o), .ready_i(b_ready_i), .data_o(b_data_o), .k_o(b_k_o),
    .err_o(b_err_o), .err_cnt_o(b_cnt), .err_sticky_o(b_sticky));
  dec10b8b_lanes #(.LANES(1)) u_c (
    .clk_i(clk), .reset_n_i(rst_n), .clear_i(c_clear_i), .v_i(c_v_i), .ready_o(c_ready_o),
    .data_i(c_data_i), .v_o(c_v_o), .ready_i(c_ready_i), .data_o(c_data_o), .k_o(c_k_o),
    .err_o(c_err_o), .err_cnt_o(c_cnt), .err_sticky_o(c_sticky));

  int unsigned n_cmp = 0, n_bad = 0, n_out_a = 0, n_out_b = 0;
  beat_a_t q_a[$];
  beat_b_t q_b[$];
  logic    a_hold = 1'b0, a_stalled = 1'b0, acc;
  logic [40:0] a_hold_val;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic setv(input int unsigned i, input logic [9:0] s, input logic [7:0] b,
                      input logic k, input logic e);
    tbl[i] = '{sym: s, b: b, k: k, e: e};
  endtask

  task automatic mk_a(input int unsigned i0, i1, i2, i3, output logic [39:0] d, output beat_a_t e);
    int unsigned ix [4];
    ix[0] = i0 % NV; ix[1] = i1 % NV; ix[2] = i2 % NV; ix[3] = i3 % NV;
    for (int n = 0; n < 4; n++) begin
      d[10*n +: 10] = tbl[ix[n]].sym;
      e.d[8*n +: 8] = tbl[ix[n]].b;
      e.k[n]        = tbl[ix[n]].k;
      e.e[n]        = tbl[ix[n]].e;
    end
  endtask

  task automatic mk_b(input int unsigned i0, i1, output logic [19:0] d, output beat_b_t e);
    d = {tbl[i1].sym, tbl[i0].sym};
    e = '{d: {tbl[i1].b, tbl[i0].b}, k: {tbl[i1].k, tbl[i0].k}, e: {tbl[i1].e, tbl[i0].e}};
  endtask

  task automatic cyc_a(input logic v, input logic [39:0] d, input beat_a_t e, input logic rdy,
                       input logic clr, output logic ok);
    @(negedge clk);
    a_v_i = v; a_data_i = d; a_ready_i = rdy; a_clear_i = clr;
    #2;
    if (a_hold) check("a_hold_stable", {a_v_o, a_data_o, a_k_o, a_err_o}, {1'b1, a_hold_val[39:0]});
    if (a_v_o && a_ready_i) begin
      beat_a_t x;
      if (q_a.size() == 0) check("a_unexpected_beat", 64'd1, 64'd0);
      else begin
        x = q_a.pop_front();
        check("a_beat", {a_data_o, a_k_o, a_err_o}, x);
        n_out_a++;
      end
    end
    a_hold     = a_v_o && !a_ready_i;
    a_hold_val = {1'b0, a_data_o, a_k_o, a_err_o};
    if (!a_ready_o) a_stalled = 1'b1;
    ok = v && a_ready_o;
    if (ok) q_a.push_back(e);
  endtask

  task automatic cyc_b(input logic v, input logic [19:0] d, input beat_b_t e, input logic rdy,
                       input logic clr, output logic ok);
    @(negedge clk);
    b_v_i = v; b_data_i = d; b_ready_i = rdy; b_clear_i = clr;
    #2;
    if (b_v_o && b_ready_i) begin
      beat_b_t x;
      if (q_b.size() == 0) check("b_unexpected_beat", 64'd1, 64'd0);
      else begin
        x = q_b.pop_front();
        check("b_beat", {b_data_o, b_k_o, b_err_o}, x);
        n_out_b++;
      end
    end
    ok = v && b_ready_o;
    if (ok && e.e == 2'b00) q_b.push_back(e);
  endtask

  task automatic send_a(input logic [39:0] d, input beat_a_t e);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) cyc_a(1'b1, d, e, 1'b1, 1'b0, ok);
    if (!ok) check("a_send_timeout", 64'd0, 64'd1);
  endtask

  task automatic send_b(input logic [19:0] d, input beat_b_t e);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) cyc_b(1'b1, d, e, 1'b1, 1'b0, ok);
    if (!ok) check("b_send_timeout", 64'd0, 64'd1);
  endtask

  task automatic idle_a(input int unsigned n);
    logic ok;
    for (int unsigned i = 0; i < n; i++) cyc_a(1'b0, '0, '0, 1'b1, 1'b0, ok);
  endtask

  task automatic idle_b(input int unsigned n);
    logic ok;
    for (int unsigned i = 0; i < n; i++) cyc_b(1'b0, '0, '0, 1'b1, 1'b0, ok);
  endtask

  task automatic drain_a();
    for (int i = 0; i < 30 && q_a.size() != 0; i++) idle_a(1);
    idle_a(2);
    check("a_drain", q_a.size(), 0);
  endtask

  task automatic drain_b();
    for (int i = 0; i < 30 && q_b.size() != 0; i++) idle_b(1);
    idle_b(2);
    check("b_drain", q_b.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [39:0] da;
    logic [19:0] db;
    beat_a_t ea;
    beat_b_t eb;
    int unsigned exp_cnt [4];
    int unsigned lat, sent, out0;
    logic [9:0] got_c;

    setv( 0, 10'b00111_00101, 8'h01, 0, 0);  setv( 1, 10'b11010_00011, 8'h80, 0, 0);
    setv( 2, 10'b00111_11000, 8'hA8, 0, 0);  setv( 3, 10'b11110_00001, 8'hC0, 0, 0);
    setv( 4, 10'b01111_10000, 8'hF6, 0, 0);  setv( 5, 10'b10100_11010, 8'h00, 1, 0);
    setv( 6, 10'b10100_11100, 8'h01, 1, 0);  setv( 7, 10'b00000_00000, 8'h00, 0, 1);
    setv( 8, 10'b11111_11111, 8'h00, 0, 1);  setv( 9, 10'b00111_00111, 8'h00, 0, 1);
    setv(10, 10'b00011_00101, 8'h00, 0, 1);  setv(11, 10'b11100_10100, 8'hF2, 0, 0);
    setv(12, 10'b01010_01101, 8'h5A, 0, 0);  setv(13, 10'b11000_00111, 8'h98, 0, 0);
    setv(14, 10'b00110_11100, 8'hBA, 0, 0);  setv(15, 10'b11000_11010, 8'hF4, 0, 0);
    setv(16, 10'b01111_00100, 8'hE2, 0, 0);  setv(17, 10'b11011_10000, 8'hEA, 0, 0);
    setv(18, 10'b01000_11101, 8'hDD, 0, 0);  setv(19, 10'b10000_10111, 8'hE7, 0, 0);
    setv(20, 10'b00010_01111, 8'hED, 0, 0);  setv(21, 10'b10000_01111, 8'hF7, 0, 0);
    setv(22, 10'b11001_10010, 8'h3F, 0, 0);  setv(23, 10'b10111_00010, 8'hCD, 0, 0);
    setv(24, 10'b00001_00001, 8'h00, 0, 1);  setv(25, 10'b10101_10100, 8'hA5, 0, 0);
    setv(26, 10'b01001_10011, 8'h6C, 0, 0);  setv(27, 10'b01110_01100, 8'h1C, 0, 0);

    {a_v_i, a_ready_i, a_clear_i, a_data_i} = '0;
    {b_v_i, b_ready_i, b_clear_i, b_data_i} = '0;
    {c_v_i, c_ready_i, c_clear_i, c_data_i} = '0;

    // reset state
    repeat (3) @(negedge clk);
    #2;
    check("a_reset_ctl", {a_v_o, a_ready_o, a_sticky}, 3'b010);
    check("a_reset_out", {a_data_o, a_k_o, a_err_o, a_cnt}, 64'd0);
    check("b_reset", {b_v_o, b_ready_o, b_sticky, b_data_o, b_k_o, b_err_o, b_cnt}, {3'b010, 24'd0});
    check("c_reset", {c_v_o, c_ready_o, c_data_o, c_cnt}, {2'b01, 16'd0});
    @(negedge clk);
    rst_n = 1'b1;

    // LANES=1 latency: v_o exactly two cycles after the accepting edge
    @(negedge clk);
    c_v_i = 1'b1; c_data_i = tbl[0].sym; c_ready_i = 1'b1;
    #2;
    check("c_accept", c_ready_o, 1);
    lat = 0; got_c = '0;
    for (int unsigned i = 1; i <= 8; i++) begin
      @(negedge clk);
      c_v_i = 1'b0;
      #2;
      if (c_v_o && lat == 0) begin
        lat = i;
        got_c = {c_data_o, c_k_o, c_err_o};
      end
    end
    check("c_latency", lat, 2);
    check("c_data", got_c, {8'h01, 1'b0, 1'b0});

    // full table through four lanes
    exp_cnt = '{default: 0};
    for (int unsigned j = 0; j < NV / 4; j++) begin
      mk_a(4*j, 4*j+1, 4*j+2, 4*j+3, da, ea);
      for (int n = 0; n < 4; n++) exp_cnt[n] += int'(tbl[4*j+n].e);
      send_a(da, ea);
    end
    drain_a();
    for (int n = 0; n < 4; n++) check("a_cnt_table", a_cnt[8*n +: 8], exp_cnt[n]);
    check("a_sticky_table", a_sticky, 1);

    cyc_a(1'b0, '0, '0, 1'b1, 1'b1, acc);
    idle_a(1);
    check("a_clear", {a_sticky, a_cnt}, 0);

    // lane-0 count steps 0->1->2->3, visible the cycle after the S1->S2 move
    for (int unsigned i = 0; i < 3; i++) begin
      mk_a(7 + i, 0, 0, 0, da, ea);
      cyc_a(1'b1, da, ea, 1'b1, 1'b0, acc);
      check("a_err_accept", acc, 1);
      idle_a(1);
      check("a_cnt_before_move", a_cnt[7:0], i);
      idle_a(1);
      check("a_cnt_after_move", a_cnt[7:0], i + 1);
      check("a_cnt_other_lanes", a_cnt[31:8], 0);
      check("a_sticky_set", a_sticky, 1);
    end
    drain_a();

    // clear in the same cycle as an increment
    mk_a(8, 0, 0, 0, da, ea);
    cyc_a(1'b1, da, ea, 1'b1, 1'b0, acc);
    cyc_a(1'b0, '0, '0, 1'b1, 1'b1, acc);
    idle_a(1);
    check("a_clear_wins", {a_sticky, a_cnt}, 0);
    drain_a();

    // backpressure: 8 beats, ready_i low for cycles 3..6
    a_stalled = 1'b0; sent = 0; out0 = n_out_a;
    for (int unsigned t = 0; t < 100 && (sent < 8 || q_a.size() != 0); t++) begin
      mk_a(4*sent, 4*sent+1, 4*sent+2, 4*sent+3, da, ea);
      cyc_a(sent < 8, da, ea, !(t >= 3 && t <= 6), 1'b0, acc);
      if (acc) sent++;
    end
    idle_a(3);
    check("bp_all_sent", sent, 8);
    check("bp_ready_low", a_stalled, 1);
    check("bp_beats_out", n_out_a - out0, 8);
    check("bp_queue_empty", q_a.size(), 0);

    // DROP_ERR=1: good, bad, good -> two beats, one count
    out0 = n_out_b;
    mk_b(0, 1, db, eb); send_b(db, eb);
    mk_b(7, 0, db, eb); send_b(db, eb);
    mk_b(2, 3, db, eb); send_b(db, eb);
    drain_b();
    check("b_drop_beats", n_out_b - out0, 2);
    check("b_drop_cnt", b_cnt, {2'd0, 2'd1});
    check("b_drop_sticky", b_sticky, 1);

    // CNT_W=2 saturation after five lane-0 errors
    cyc_b(1'b0, '0, '0, 1'b1, 1'b1, acc);
    out0 = n_out_b;
    for (int unsigned i = 0; i < 5; i++) begin
      mk_b(7 + (i % 3), 0, db, eb);
      send_b(db, eb);
    end
    drain_b();
    check("b_saturate", b_cnt, {2'd0, 2'd3});
    check("b_saturate_no_out", n_out_b - out0, 0);

    // reset mid-stream discards in-flight beats
    out0 = n_out_b;
    mk_b(11, 12, db, eb); cyc_b(1'b1, db, eb, 1'b0, 1'b0, acc);
    mk_b(13, 14, db, eb); cyc_b(1'b1, db, eb, 1'b0, 1'b0, acc);
    @(negedge clk);
    b_v_i = 1'b0;
    #2;
    check("b_vo_before_reset", b_v_o, 1);
    #1 rst_n = 1'b0;
    #1;
    check("b_vo_in_reset", {b_v_o, a_v_o, b_ready_o}, 3'b001);
    check("b_cnt_in_reset", {b_sticky, b_cnt}, 0);
    q_b.delete();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    idle_b(6);
    check("b_no_stale_beat", n_out_b - out0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
